// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a five-stage in-order pipeline: operand
// interlocks, branch dependencies, redirect squashing and a multicycle mul/div sequencer.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_is_branch,
  input  logic [4:0] e_dst,
  input  logic       e_wr,
  input  logic       e_is_load,
  input  logic [4:0] m_dst,
  input  logic       m_wr,
  input  logic       m_is_load,
  input  logic       e_redirect,
  input  logic       e_muldiv_start,
  input  logic       e_muldiv_op,
  input  logic       i_stall,
  input  logic       d_stall,
  output logic       en_pc,
  output logic       en_fd,
  output logic       en_de,
  output logic       en_em,
  output logic       en_mw,
  output logic       clr_fd,
  output logic       clr_de,
  output logic       clr_em,
  output logic       clr_mw,
  output logic       muldiv_busy,
  output logic       muldiv_done,
  output logic       redirect_pending
);

  // The start cycle is the first stall cycle, so the counter holds L-1.
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  md_state_t  state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [5:0] lat_cnt;
  logic       pending, pending_nxt;
  logic       mdstall, busy_raw, done_raw;

  logic       e_hit, m_hit;
  logic       load_use, br_dep;
  logic       stall_m, stall_e, stall_d, stall_f;
  logic       redir_take;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdstall   = 1'b0;
    busy_raw  = 1'b0;
    done_raw  = 1'b0;
    lat_cnt   = e_muldiv_op ? DIV_CNT : MUL_CNT;
    case (state)
      IDLE: begin
        if (e_muldiv_start) begin
          mdstall   = 1'b1;
          busy_raw  = 1'b1;
          cnt_nxt   = lat_cnt;
          state_nxt = (lat_cnt == 6'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        mdstall  = 1'b1;
        busy_raw = 1'b1;
        if (cnt <= 6'd1) begin
          cnt_nxt   = 6'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      DONE: begin
        done_raw = 1'b1;
        // In DONE, E is held only by the memory stall.
        if (!d_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    e_hit    = (e_dst != 5'd0) && ((e_dst == d_rs) || (e_dst == d_rt));
    m_hit    = (m_dst != 5'd0) && ((m_dst == d_rs) || (m_dst == d_rt));
    load_use = e_wr && e_is_load && e_hit;
    br_dep   = d_is_branch && ((e_wr && e_hit) || (m_wr && m_is_load && m_hit));

    stall_m    = d_stall;
    stall_e    = stall_m || mdstall;
    stall_d    = stall_e || load_use || br_dep;
    stall_f    = stall_d || i_stall;
    redir_take = e_redirect && !stall_e;

    pending_nxt = pending;
    if (redir_take && i_stall) pending_nxt = 1'b1;
    else if (pending && !i_stall && !stall_d) pending_nxt = 1'b0;
  end

  // Outputs are forced to the flushed state while reset is held.
  always_comb begin
    en_pc       = 1'b0;
    en_fd       = 1'b0;
    en_de       = 1'b0;
    en_em       = 1'b0;
    en_mw       = 1'b0;
    clr_fd      = 1'b1;
    clr_de      = 1'b1;
    clr_em      = 1'b1;
    clr_mw      = 1'b1;
    muldiv_busy = 1'b0;
    muldiv_done = 1'b0;
    if (resetn) begin
      en_pc       = !stall_f || redir_take;
      en_fd       = !stall_d;
      en_de       = !stall_e;
      en_em       = !stall_m;
      en_mw       = 1'b1;
      clr_fd      = (i_stall && !stall_d) || redir_take || (pending && !stall_d);
      clr_de      = (stall_d && !stall_e) || redir_take;
      clr_em      = stall_e && !stall_m;
      clr_mw      = stall_m;
      muldiv_busy = busy_raw;
      muldiv_done = done_raw;
    end
  end

  assign redirect_pending = pending;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle comparison against a
// cycle-count model of the stall rules, plus hand-computed spot checks.
module tb_pipeline_hazard_ctrl;
  localparam int ML = 2;
  localparam int DL = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, e_dst = '0, m_dst = '0;
  logic       d_is_branch = 1'b0, e_wr = 1'b0, e_is_load = 1'b0;
  logic       m_wr = 1'b0, m_is_load = 1'b0, e_redirect = 1'b0;
  logic       e_muldiv_start = 1'b0, e_muldiv_op = 1'b0;
  logic       i_stall = 1'b0, d_stall = 1'b0;
  logic       en_pc, en_fd, en_de, en_em, en_mw;
  logic       clr_fd, clr_de, clr_em, clr_mw;
  logic       muldiv_busy, muldiv_done, redirect_pending;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Model state: remaining stall cycles, finished-result flag, pending squash.
  int md_left = 0;
  bit md_done = 1'b0;
  bit pend = 1'b0;

  pipeline_hazard_ctrl #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt), .d_is_branch(d_is_branch),
    .e_dst(e_dst), .e_wr(e_wr), .e_is_load(e_is_load),
    .m_dst(m_dst), .m_wr(m_wr), .m_is_load(m_is_load),
    .e_redirect(e_redirect), .e_muldiv_start(e_muldiv_start), .e_muldiv_op(e_muldiv_op),
    .i_stall(i_stall), .d_stall(d_stall),
    .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  function automatic bit uses(input logic [4:0] r);
    return (r != 5'd0) && (r == d_rs || r == d_rt);
  endfunction

  function automatic bit load_use();
    return e_wr && e_is_load && uses(e_dst);
  endfunction

  function automatic bit br_dep();
    return d_is_branch && ((e_wr && uses(e_dst)) || (m_wr && m_is_load && uses(m_dst)));
  endfunction

  function automatic bit md_stalling();
    return (md_left > 0) || (!md_done && e_muldiv_start);
  endfunction

  function automatic logic [11:0] expected();
    bit se, sd, sf, take;
    if (!resetn) return {5'b00000, 4'b1111, 2'b00, pend};
    se   = d_stall || md_stalling();
    sd   = se || load_use() || br_dep();
    sf   = sd || i_stall;
    take = e_redirect && !se;
    return {!sf || take, !sd, !se, !d_stall, 1'b1,
            (i_stall && !sd) || take || (pend && !sd),
            (sd && !se) || take, se && !d_stall, d_stall,
            md_stalling(), md_done, pend};
  endfunction

  always @(posedge clk) begin
    bit sd, start_now, take;
    if (!resetn) begin
      md_left = 0;
      md_done = 1'b0;
      pend = 1'b0;
    end else begin
      start_now = (md_left == 0) && !md_done && e_muldiv_start;
      sd   = d_stall || md_stalling() || load_use() || br_dep();
      take = e_redirect && !(d_stall || md_stalling());
      if (take && i_stall) pend = 1'b1;
      else if (pend && !i_stall && !sd) pend = 1'b0;
      if (start_now) begin
        md_left = (e_muldiv_op ? DL : ML) - 1;
        md_done = (md_left == 0);
      end else if (md_left > 0) begin
        md_left--;
        md_done = (md_left == 0);
      end else if (md_done && !d_stall) begin
        md_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] got, exp;
    if (started) begin
      got = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw,
             muldiv_busy, muldiv_done, redirect_pending};
      exp = expected();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model t=%0t outputs got=%b expected=%b", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {d_rs, d_rt, e_dst, m_dst} = '0;
    {d_is_branch, e_wr, e_is_load, m_wr, m_is_load, e_redirect} = '0;
    {e_muldiv_start, e_muldiv_op, i_stall, d_stall} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit seen;
    resetn = 1'b0;
    tick();
    started = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_en_pc", en_pc, 0);
    chk("rst_en_mw", en_mw, 0);
    chk("rst_clr_fd", clr_fd, 1);
    chk("rst_clr_mw", clr_mw, 1);
    chk("rst_pending", redirect_pending, 0);

    tick(); resetn = 1'b1;
    @(negedge clk);
    chk("idle_en_pc", en_pc, 1);
    chk("idle_clr_de", clr_de, 0);

    // Load-use on r5, then the same with r0 as destination.
    tick(); e_wr = 1; e_is_load = 1; e_dst = 5; d_rs = 5;
    @(negedge clk);
    chk("lu_en_pc", en_pc, 0);
    chk("lu_en_fd", en_fd, 0);
    chk("lu_clr_de", clr_de, 1);
    chk("lu_en_de", en_de, 1);
    tick(); e_dst = 0; d_rs = 0;
    @(negedge clk);
    chk("r0_en_pc", en_pc, 1);
    chk("r0_clr_de", clr_de, 0);
    tick(); clear_inputs();

    // Branch dependencies on E result and on an M-stage load.
    tick(); d_is_branch = 1; e_wr = 1; e_dst = 3; d_rt = 3;
    @(negedge clk); chk("br_e_en_fd", en_fd, 0);
    tick(); e_wr = 0; m_wr = 1; m_is_load = 1; m_dst = 3;
    @(negedge clk); chk("br_mload_en_fd", en_fd, 0);
    tick(); m_is_load = 0;
    @(negedge clk); chk("br_malu_en_fd", en_fd, 1);
    tick(); clear_inputs();

    // Multiply: two stall cycles then DONE.
    tick(); e_muldiv_start = 1; e_muldiv_op = 0;
    @(negedge clk);
    chk("mul0_busy", muldiv_busy, 1);
    chk("mul0_en_de", en_de, 0);
    chk("mul0_clr_em", clr_em, 1);
    chk("mul0_clr_de", clr_de, 0);
    tick(); @(negedge clk);
    chk("mul1_en_de", en_de, 0);
    tick(); @(negedge clk);
    chk("mul2_done", muldiv_done, 1);
    chk("mul2_busy", muldiv_busy, 0);
    chk("mul2_en_de", en_de, 1);
    tick(); e_muldiv_start = 0;
    @(negedge clk); chk("mul3_done", muldiv_done, 0);

    // Divide: count stall cycles until the result is announced.
    tick(); e_muldiv_start = 1; e_muldiv_op = 1;
    stalls = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (muldiv_done) begin seen = 1; break; end
      if (!en_de && clr_em) stalls++;
      tick();
    end
    chk("div_done_seen", seen, 1);
    chk("div_stall_cycles", stalls, 32);
    chk("div_done_en_de", en_de, 1);
    tick(); clear_inputs();

    // Memory stall while a multiply result waits in DONE.
    tick(); e_muldiv_start = 1;
    tick();
    tick(); d_stall = 1;
    @(negedge clk);
    chk("hold_done", muldiv_done, 1);
    chk("hold_en_de", en_de, 0);
    chk("hold_en_em", en_em, 0);
    chk("hold_clr_mw", clr_mw, 1);
    tick(); tick();
    @(negedge clk);
    chk("hold3_done", muldiv_done, 1);
    chk("hold3_busy", muldiv_busy, 0);
    tick(); d_stall = 0;
    @(negedge clk);
    chk("release_en_de", en_de, 1);
    tick(); e_muldiv_start = 0;
    @(negedge clk);
    chk("release_idle_done", muldiv_done, 0);
    chk("release_idle_busy", muldiv_busy, 0);

    // Redirect beats a simultaneous load-use.
    tick(); e_wr = 1; e_is_load = 1; e_dst = 7; d_rs = 7; e_redirect = 1;
    @(negedge clk);
    chk("redir_clr_fd", clr_fd, 1);
    chk("redir_clr_de", clr_de, 1);
    chk("redir_en_pc", en_pc, 1);
    tick(); clear_inputs();

    // Redirect is held off while a multiply stalls E.
    tick(); e_muldiv_start = 1; e_redirect = 1;
    @(negedge clk);
    chk("redir_md_en_pc", en_pc, 0);
    chk("redir_md_clr_fd", clr_fd, 0);
    tick(); tick();
    @(negedge clk);
    chk("redir_md_taken_clr_fd", clr_fd, 1);
    chk("redir_md_taken_en_pc", en_pc, 1);
    tick(); clear_inputs();

    // Redirect while fetch is stalled leaves a pending squash.
    tick(); i_stall = 1; e_redirect = 1;
    @(negedge clk);
    chk("pend0_en_pc", en_pc, 1);
    chk("pend0_flag", redirect_pending, 0);
    tick(); e_redirect = 0;
    @(negedge clk);
    chk("pend1_flag", redirect_pending, 1);
    chk("pend1_en_pc", en_pc, 0);
    tick();
    tick(); i_stall = 0;
    @(negedge clk);
    chk("pend_fetch_flag", redirect_pending, 1);
    chk("pend_fetch_clr_fd", clr_fd, 1);
    tick();
    @(negedge clk);
    chk("pend_after_flag", redirect_pending, 0);
    chk("pend_after_clr_fd", clr_fd, 0);

    // Reset in cycle 10 of a divide aborts it.
    tick(); e_muldiv_start = 1; e_muldiv_op = 1;
    for (int i = 0; i < 10; i++) tick();
    resetn = 0;
    @(negedge clk);
    chk("abort_busy", muldiv_busy, 0);
    chk("abort_clr_em", clr_em, 1);
    chk("abort_en_pc", en_pc, 0);
    tick(); resetn = 1; e_muldiv_start = 0;
    @(negedge clk);
    chk("abort_idle_busy", muldiv_busy, 0);
    chk("abort_idle_en_de", en_de, 1);
    tick(); e_muldiv_start = 1; e_muldiv_op = 0;
    tick(); tick();
    @(negedge clk);
    chk("post_abort_mul_done", muldiv_done, 1);
    tick(); clear_inputs();
    tick();

    @(posedge clk);
    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, meaning E-stage stall cycles for multiply.
REQ-002 SHALL have parameter DIV_LAT, default 32, meaning E-stage stall cycles for divide.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports d_rs, d_rt  in  5 each  source register numbers of the instruction in D.
REQ-006 SHALL have port d_is_branch  in  1  D instruction compares operands in D.
REQ-007 SHALL have ports e_dst  in  5, e_wr  in  1, e_is_load  in  1  describing the E instruction.
REQ-008 SHALL have ports m_dst  in  5, m_wr  in  1, m_is_load  in  1  describing the M instruction.
REQ-009 SHALL have port e_redirect  in  1  E instruction redirects the PC; F and D contents are wrong-path.
REQ-010 SHALL have ports e_muldiv_start  in  1, e_muldiv_op  in  1 (0=mul, 1=div)  describing a mul/div in E.
REQ-011 SHALL have ports i_stall  in  1 (fetch waiting) and d_stall  in  1 (M-stage memory waiting).
REQ-012 SHALL have outputs en_pc, en_fd, en_de, en_em, en_mw  out  1 each  pipeline register enables.
REQ-013 SHALL have outputs clr_fd, clr_de, clr_em, clr_mw  out  1 each  pipeline register clears; clear has priority over enable at the register.
REQ-014 SHALL have outputs muldiv_busy, muldiv_done, redirect_pending  out  1 each.

Function
REQ-015 SHALL compute stalls combinationally: stall_m = d_stall; stall_e = stall_m | mdstall; stall_d = stall_e | load_use | br_dep; stall_f = stall_d | i_stall.
REQ-016 SHALL assert load_use when e_wr & e_is_load & e_dst!=0 & (e_dst==d_rs | e_dst==d_rt).
REQ-017 SHALL assert br_dep when d_is_branch & ((e_wr & e_dst!=0 & e_dst matches d_rs/d_rt) | (m_wr & m_is_load & m_dst!=0 & m_dst matches d_rs/d_rt)).
REQ-018 SHALL drive en_pc=~stall_f, en_fd=~stall_d, en_de=~stall_e, en_em=~stall_m, en_mw=1.
REQ-019 SHALL drive bubbles: clr_de=stall_d&~stall_e; clr_em=stall_e&~stall_m; clr_mw=stall_m; clr_fd=i_stall&~stall_d.
REQ-020 SHALL, when e_redirect & ~stall_e, assert clr_fd=1 and clr_de=1 and force en_pc=1, overriding load_use/br_dep.
REQ-021 SHALL set redirect_pending when a redirect is taken while i_stall=1; while set, clr_fd=1 whenever en_fd would load; clears in the cycle i_stall is low and D is not stalled.
REQ-022 SHALL implement mul/div FSM IDLE, BUSY, DONE with a 6-bit down-counter.
REQ-023 SHALL, in IDLE with e_muldiv_start=1, assert mdstall, load counter from MUL_LAT or DIV_LAT, go BUSY.
REQ-024 SHALL assert mdstall for exactly L consecutive cycles (L=latency) beginning with the start cycle, then enter DONE.
REQ-025 SHALL in DONE deassert mdstall, assert muldiv_done, return to IDLE only when en_de=1; stay in DONE while stall_m holds E.
REQ-026 SHALL keep counting during d_stall; SHALL not restart while e_muldiv_start remains high in DONE.
REQ-027 SHALL assert muldiv_busy in BUSY and in the IDLE start cycle.
REQ-028 SHALL treat register 0 as never causing a dependency.

Reset
REQ-029 SHALL, on posedge clk with resetn=0, set FSM=IDLE, counter=0, redirect_pending=0.
REQ-030 SHALL, while resetn=0, drive all en_*=0, all clr_*=1, muldiv_busy=muldiv_done=0; reset mid-divide aborts it.

Verification
REQ-031 SHALL cover load-use: e_is_load,e_wr,e_dst=5,d_rs=5 -> en_pc=en_fd=0, clr_de=1 for one cycle; same with e_dst=0 -> no stall.
REQ-032 SHALL cover divide: start with op=1 -> mdstall 32 cycles, clr_em=1 each, muldiv_done in cycle 32, en_de=1 there; mul -> 2 cycles.
REQ-033 SHALL cover d_stall during DONE of a mul -> FSM holds DONE, no restart, returns IDLE when d_stall drops.
REQ-034 SHALL cover e_redirect with load_use same cycle -> clr_fd=clr_de=1, en_pc=1.
REQ-035 SHALL cover redirect during i_stall=1 for 3 cycles -> redirect_pending=1, first fetch on i_stall=0 cleared (clr_fd=1), pending then 0.
REQ-036 SHALL cover resetn=0 at divide cycle 10 -> IDLE next cycle, muldiv_busy=0, all clr_*=1.
